// File: rtl/traffic_sink_pkg.sv
// Shared network width macros plus the traffic_sink package: derived widths,
// pop classification type and the saturating counter helper.
`ifndef TRAFFIC_NOC_DEFINES
`define TRAFFIC_NOC_DEFINES
`define PAYLOAD_SIZE 8
`define ADDR_SZ 4
`define NUM_NODES 16
`endif

package traffic_sink_pkg;

    localparam int ADDR_W = `ADDR_SZ;
    localparam int SRC_W  = `PAYLOAD_SIZE;
    localparam int PKT_W  = `PAYLOAD_SIZE + `ADDR_SZ;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_RX   = 2'd1,
        POP_ERR  = 2'd2
    } pop_kind_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        logic [CNT_W-1:0] result;
        result = value;
        if (en && (value != CNT_MAX)) begin
            result = value + 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/traffic_sink_fifo.sv
// sink_fifo: power-of-two circular buffer with occupancy count; a push into a
// full buffer is accepted when a pop happens in the same cycle.
module sink_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      occ_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pop only real data; a pop frees the slot a same-cycle push may take.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && (occ_r != {(AW+1){1'b0}})) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && ((occ_r != OCC_FULL) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + (AW+1)'(1);
                2'b01:   occ_r <= occ_r - (AW+1)'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata     = mem_r[rd_ptr_r];
    assign full      = (occ_r == OCC_FULL);
    assign empty     = (occ_r == {(AW+1){1'b0}});
    assign occupancy = occ_r;

endmodule

// File: rtl/traffic_sink.sv
// traffic_sink: buffers incoming packets, drains them at a fixed period and
// classifies each popped packet as correctly addressed or misrouted.
module traffic_sink
    import traffic_sink_pkg::*;
#(
    parameter int id           = -1,
    parameter int expected     = 1,
    parameter int drain_period = 4,
    parameter int depth        = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req,
    input  logic [`PAYLOAD_SIZE+`ADDR_SZ-1:0] data,
    output logic                              busy,
    output logic [15:0]                       rx_count,
    output logic [15:0]                       err_count,
    output logic [15:0]                       drop_count,
    output logic [`PAYLOAD_SIZE-1:0]          last_src,
    output logic                              done
);

    localparam int OCC_W = $clog2(depth) + 1;
    localparam logic [7:0]       DRAIN_LAST = 8'(drain_period - 1);
    localparam logic [OCC_W-1:0] BUSY_LEVEL = OCC_W'(depth - 1);

    logic [7:0]       drain_cnt_r;
    logic             busy_r;
    logic [CNT_W-1:0] rx_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] drop_count_r;
    logic [SRC_W-1:0] last_src_r;
    logic             done_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [OCC_W-1:0] occ_s;
    logic [PKT_W-1:0] head_s;
    logic [ADDR_W-1:0] head_dest_s;
    logic [SRC_W-1:0] head_src_s;
    logic             pop_s;
    logic             accept_s;
    logic             drop_s;
    logic [OCC_W-1:0] next_occ_s;
    pop_kind_e        kind_s;

    sink_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req),
        .pop       (pop_s),
        .wdata     (data),
        .rdata     (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .occupancy (occ_s)
    );

    // Pop decision, head classification and projected occupancy.
    always_comb begin
        head_dest_s = head_s[ADDR_W-1:0];
        head_src_s  = head_s[PKT_W-1:ADDR_W];
        pop_s       = (drain_cnt_r == DRAIN_LAST) && !fifo_empty_s;
        accept_s    = req && (!fifo_full_s || pop_s);
        drop_s      = req && fifo_full_s && !pop_s;
        kind_s      = POP_NONE;
        next_occ_s  = occ_s;
        if (pop_s) begin
            if (int'(head_dest_s) == id) begin
                kind_s = POP_RX;
            end else begin
                kind_s = POP_ERR;
            end
        end else begin
            kind_s = POP_NONE;
        end
        if (accept_s && !pop_s) begin
            next_occ_s = occ_s + OCC_W'(1);
        end else if (!accept_s && pop_s) begin
            next_occ_s = occ_s - OCC_W'(1);
        end else begin
            next_occ_s = occ_s;
        end
    end

    // Free-running drain phase counter; the wrap cycle is the pop slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt_r <= 8'd0;
        end else if (drain_cnt_r == DRAIN_LAST) begin
            drain_cnt_r <= 8'd0;
        end else begin
            drain_cnt_r <= drain_cnt_r + 8'd1;
        end
    end

    // Statistics, last source, sticky completion flag and back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_count_r   <= 16'd0;
            err_count_r  <= 16'd0;
            drop_count_r <= 16'd0;
            last_src_r   <= {SRC_W{1'b0}};
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            rx_count_r   <= sat_inc(rx_count_r, kind_s == POP_RX);
            err_count_r  <= sat_inc(err_count_r, kind_s == POP_ERR);
            drop_count_r <= sat_inc(drop_count_r, drop_s);
            if (kind_s == POP_RX) begin
                last_src_r <= head_src_s;
            end
            // Compares the pre-update count, so done lands one cycle late.
            done_r <= done_r | (int'(rx_count_r) == expected);
            busy_r <= (next_occ_s >= BUSY_LEVEL);
        end
    end

`ifndef SYNTHESIS
    // Simulation log of each classified pop.
    always_ff @(posedge clk) begin
        if (!reset && (id != -1)) begin
            if (kind_s == POP_RX) begin
                $display("##,rx,%d,%d", id, head_src_s);
            end else if (kind_s == POP_ERR) begin
                $display("##,err,%d,%d", id, head_dest_s);
            end
        end
    end
`endif

    assign busy       = busy_r;
    assign rx_count   = rx_count_r;
    assign err_count  = err_count_r;
    assign drop_count = drop_count_r;
    assign last_src   = last_src_r;
    assign done       = done_r;

endmodule
